// File: rtl/mac_mul_sign_restorer_pkg.sv
// Shared cfg bit indices, mode encodings and per-segment decode helpers for the
// multiplier sign restorer.
package mac_mul_sign_restorer_pkg;

    localparam int SIGNED_BIT = 3;
    localparam int MAC_BIT    = 2;

    localparam logic [1:0] MODE_SINGLE     = 2'b00;
    localparam logic [1:0] MODE_DUAL       = 2'b01;
    localparam logic [1:0] MODE_QUAD       = 2'b10;
    localparam logic [1:0] MODE_SINGLE_ALT = 2'b11;

    localparam int NUM_SEGS = 4;

    typedef enum logic [1:0] {
        SEG_SINGLE = 2'd0,
        SEG_DUAL   = 2'd1,
        SEG_QUAD   = 2'd2
    } seg_mode_e;

    function automatic seg_mode_e decode_mode(input logic [1:0] m);
        if (m == MODE_QUAD)      return SEG_QUAD;
        else if (m == MODE_DUAL) return SEG_DUAL;
        else                     return SEG_SINGLE;
    endfunction

    // Carry-in of segment seg given the carry-out of the segment below it.
    function automatic logic seg_cin(input seg_mode_e m, input int seg, input logic prev_cout);
        case (seg)
            1:       return (m == SEG_SINGLE) ? 1'b1 : prev_cout;
            2:       return (m == SEG_QUAD) ? prev_cout : 1'b1;
            3:       return (m == SEG_SINGLE) ? 1'b1 : prev_cout;
            default: return 1'b1;
        endcase
    endfunction

    // A segment takes the negated value from the flag of the top lane of its group.
    function automatic logic seg_take_bar(input seg_mode_e m, input int seg, input logic [3:0] neg);
        case (m)
            SEG_QUAD: return neg[3];
            SEG_DUAL: return (seg < 2) ? neg[1] : neg[3];
            default:  return neg[seg];
        endcase
    endfunction

endpackage

// File: rtl/mac_mul_sign_restorer_adder.sv
// Plain N-bit ripple adder with carry in/out; one instance per product segment.
module n_bit_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);
    logic [N:0] sum_w;

    assign sum_w  = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};
    assign sum_o  = sum_w[N-1:0];
    assign cout_o = sum_w[N];
endmodule

// File: rtl/mac_mul_sign_restorer.sv
// Re-applies product sign to unsigned multiplier magnitudes, with cfg and sign flags
// delayed to line up with the multiplier latency.
module mac_mul_sign_restorer
    import mac_mul_sign_restorer_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH,
    parameter int MUL_LATENCY    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic [MAC_CONF_WIDTH-1:0]   cfg,
    input  logic                        C0_neg,
    input  logic                        C1_neg,
    input  logic                        C2_neg,
    input  logic                        C3_neg,
    input  logic [4*MAC_MULT_WIDTH-1:0] prod_in,
    output logic [4*MAC_MULT_WIDTH-1:0] prod_out,
    output logic                        out_valid,
    output logic [MAC_CONF_WIDTH-1:0]   out_cfg
);
    localparam int W = MAC_MULT_WIDTH;

    logic [MUL_LATENCY-1:0]                     dly_vld_q;
    logic [MUL_LATENCY-1:0][MAC_CONF_WIDTH-1:0] dly_cfg_q;
    logic [MUL_LATENCY-1:0][NUM_SEGS-1:0]       dly_neg_q;

    for (genvar s = 0; s < MUL_LATENCY; s++) begin : g_dly
        logic                      vld_d;
        logic [MAC_CONF_WIDTH-1:0] cfg_d;
        logic [NUM_SEGS-1:0]       neg_d;

        if (s == 0) begin : g_head
            assign vld_d = in_valid;
            assign cfg_d = cfg;
            assign neg_d = {C3_neg, C2_neg, C1_neg, C0_neg};
        end else begin : g_body
            assign vld_d = dly_vld_q[s-1];
            assign cfg_d = dly_cfg_q[s-1];
            assign neg_d = dly_neg_q[s-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                dly_vld_q[s] <= 1'b0;
                dly_cfg_q[s] <= '0;
                dly_neg_q[s] <= '0;
            end else if (en) begin
                dly_vld_q[s] <= vld_d;
                dly_cfg_q[s] <= cfg_d;
                dly_neg_q[s] <= neg_d;
            end
        end
    end

    logic [MAC_CONF_WIDTH-1:0] cfg_l;
    logic [NUM_SEGS-1:0]       neg_l;
    seg_mode_e                 mode;

    assign cfg_l = dly_cfg_q[MUL_LATENCY-1];
    assign neg_l = dly_neg_q[MUL_LATENCY-1];
    assign mode  = decode_mode(cfg_l[1:0]);

    logic [4*W-1:0] prod_d;

    // Carries ripple upward only across segment boundaries that belong to one operand.
    for (genvar i = 0; i < NUM_SEGS; i++) begin : g_seg
        logic         cin;
        logic         cout;
        logic [W-1:0] bar;
        logic         take;

        if (i == 0) begin : g_cin0
            assign cin = 1'b1;
        end else begin : g_cinn
            assign cin = seg_cin(mode, i, g_seg[i-1].cout);
        end

        n_bit_adder #(.N(W)) u_neg (
            .a_i    (~prod_in[i*W +: W]),
            .b_i    ({W{1'b0}}),
            .cin_i  (cin),
            .sum_o  (bar),
            .cout_o (cout)
        );

        assign take             = cfg_l[SIGNED_BIT] & seg_take_bar(mode, i, neg_l);
        assign prod_d[i*W +: W] = take ? bar : prod_in[i*W +: W];
    end

    logic [4*W-1:0]            prod_q;
    logic                      out_valid_q;
    logic [MAC_CONF_WIDTH-1:0] out_cfg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            out_cfg_q   <= '0;
        end else if (en) begin
            prod_q      <= prod_d;
            out_valid_q <= dly_vld_q[MUL_LATENCY-1];
            out_cfg_q   <= cfg_l;
        end
    end

    assign prod_out  = prod_q;
    assign out_valid = out_valid_q;
    assign out_cfg   = out_cfg_q;

endmodule
